kernel_mem_scratchpad: RTL and testbench
========================================

# kernel_mem_scratchpad

Responder for the kernel memory interface: serves kernel-issued Avalon-MM burst reads and writes from an on-chip scratchpad RAM and generates per-burst `writeack`. It sits on the ASP side of the kernel memory path, implementing the `asp` modport, which takes commands in and returns data and acks. It is used as a local-memory stand-in for bring-up and for small boards with no external memory.

## Interface
- `ADDR_WIDTH`, `ofs_asp_pkg::ASP_LOCALMEM_AVMM_ADDR_WIDTH`: byte address width.
- `DATA_WIDTH`, `ofs_asp_pkg::ASP_LOCALMEM_AVMM_DATA_WIDTH`: beat width in bits.
- `BURSTCOUNT_WIDTH`, `ofs_asp_pkg::ASP_LOCALMEM_QSYS_BURSTCNT_WIDTH`: burstcount width.
- `BYTEENABLE_WIDTH`, `ofs_asp_pkg::ASP_LOCALMEM_AVMM_BYTEENABLE_WIDTH`: equals DATA_WIDTH/8.
- `DEPTH_LOG2`, 10: scratchpad depth in words, log2.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `read` in 1: read command.
- `write` in 1: write beat.
- `address` in ADDR_WIDTH: byte address. Sampled only on the first beat of a burst.
- `burstcount` in BURSTCOUNT_WIDTH: beats in the burst. Sampled on the first beat.
- `writedata` in DATA_WIDTH: write beat data.
- `byteenable` in BYTEENABLE_WIDTH: per-byte write enable.
- `waitrequest` out 1: command/beat not accepted this cycle.
- `readdata` out DATA_WIDTH: read beat data.
- `readdatavalid` out 1: `readdata` valid.
- `writeack` out 1: one-cycle pulse per completed write burst.

## Operation
- Word index is `address[DEPTH_LOG2+log2(BYTEENABLE_WIDTH)-1 : log2(BYTEENABLE_WIDTH)]`. Upper bits are ignored, so addresses alias. Low bits are ignored.
- Burst beats use consecutive word indices, wrapping modulo 2^DEPTH_LOG2.
- `burstcount` of 0 is treated as 1.
- FSM states: IDLE, WR, RD.
- IDLE:
  - `waitrequest`=0.
  - `write`=1: beat 0 is written and the beat counter is loaded with N-1. Go to WR if N>1; otherwise schedule `writeack`.
  - `read`=1 (and `write`=0): word 0 is issued to the RAM. Go to RD if N>1.
  - `read` and `write` both 1: the write wins and the read is dropped. This is a protocol violation; a simulation-only assertion fires.
- WR:
  - `waitrequest`=0.
  - Each cycle with `write`=1 writes one beat with its `byteenable` and decrements the counter. Gaps are allowed.
  - The last beat returns the FSM to IDLE and schedules `writeack`.
  - `read` in WR is ignored (assertion).
- RD:
  - `waitrequest`=1.
  - One word address is issued per cycle until all N are issued, then the FSM returns to IDLE.
- The read return path is a 2-stage pipeline: RAM read, then output register. It drains independently of the FSM, so a new command may be accepted while earlier read beats are still returning.
- Read vs. later write to the same word: a read issued before the write returns old data.
- `writeack` and `readdatavalid` may assert in the same cycle.
- Reset mid-operation:
  - FSM goes to IDLE and counters clear.
  - The read pipeline is flushed: no further `readdatavalid`.
  - No `writeack` is issued for a partial burst.
  - RAM contents are retained.

## Timing
- Reset values: `waitrequest`=1 while `reset`=1; `readdatavalid`=0, `writeack`=0, `readdata`=0.
- Write, N beats, first accepted at T with no gaps: beats at T..T+N-1; `writeack` at T+N (one cycle after the last beat).
- Read, N beats, accepted at T:
  - Addresses are issued at T..T+N-1.
  - `waitrequest`=1 at T+1..T+N-1, and 0 again at T+N.
  - `readdatavalid` at T+2..T+N+1, contiguous.
- N=1 read: `waitrequest` never rises; data arrives at T+2.
- Maximum throughput: one beat per cycle in each direction. A read command can be accepted in the cycle after a prior read's last address issue.

## Structure
- Add `kernel_mem_scratchpad_state_e` (IDLE, WR, RD) and `KMS_DEFAULT_DEPTH_LOG2 = 10` to `ofs_asp_pkg`.
- Sub-module `kernel_mem_scratchpad_ram`:
  - Simple dual-port RAM: one write port with byte enables, one read port.
  - 1-cycle registered read; old-data read-during-write behaviour.
  - Parameterised by DATA_WIDTH and DEPTH_LOG2.
- Top level holds the FSM, beat counter, address incrementer, read-valid shift pipeline and `writeack` register.

## Test plan
- Single write: addr 0x40, data 0xA5 pattern, `byteenable` all ones at T → `writeack` at T+1. Then read addr 0x40, N=1 at T' → `readdatavalid` with 0xA5 pattern at T'+2.
- Write burst N=4 at word 0x3FE (wrap): beats land at words 0x3FE, 0x3FF, 0x000, 0x001. Read burst N=4 from 0x3FE → 4 contiguous valid beats in the same order; `waitrequest` high for exactly 3 cycles.
- Partial byteenable: write all-ones, then write zeros with `byteenable`=0x1 → read returns byte 0 = 0x00 and every other byte = 0xFF.
- Write burst N=3 with a 2-cycle `write` gap after beat 1 → `writeack` exactly one cycle after beat 2, and only one pulse.
- Read N=8 immediately followed by a write to word 0 of that burst: the write is accepted once `waitrequest` drops, the read returns pre-write data, and `writeack` overlaps the `readdatavalid` stream.
- Assert `reset` mid read burst (after 3 beats returned): no further `readdatavalid`; `waitrequest`=1 during reset and 0 the cycle after; earlier written data is still readable.

Source files
------------

// File: rtl/ofs_asp_pkg.sv
// Shared ASP-side constants and types for the kernel local-memory path.
package ofs_asp_pkg;

  localparam int unsigned ASP_LOCALMEM_AVMM_ADDR_WIDTH       = 32;
  localparam int unsigned ASP_LOCALMEM_AVMM_DATA_WIDTH       = 64;
  localparam int unsigned ASP_LOCALMEM_QSYS_BURSTCNT_WIDTH   = 5;
  localparam int unsigned ASP_LOCALMEM_AVMM_BYTEENABLE_WIDTH = ASP_LOCALMEM_AVMM_DATA_WIDTH / 8;

  localparam int unsigned KMS_DEFAULT_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd
  } kernel_mem_scratchpad_state_e;

endpackage

// File: rtl/kernel_mem_scratchpad_ram.sv
// Simple dual-port RAM: byte-enabled write port, 1-cycle registered read port (old data on
// read-during-write).
module kernel_mem_scratchpad_ram #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/kernel_mem_scratchpad.sv
// Avalon-MM burst responder backed by an on-chip scratchpad; per-burst writeack, 2-cycle reads.
module kernel_mem_scratchpad
  import ofs_asp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = ASP_LOCALMEM_AVMM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = ASP_LOCALMEM_AVMM_DATA_WIDTH,
  parameter int unsigned BURSTCOUNT_WIDTH = ASP_LOCALMEM_QSYS_BURSTCNT_WIDTH,
  parameter int unsigned BYTEENABLE_WIDTH = ASP_LOCALMEM_AVMM_BYTEENABLE_WIDTH,
  parameter int unsigned DEPTH_LOG2       = KMS_DEFAULT_DEPTH_LOG2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        read,
  input  logic                        write,
  input  logic [ADDR_WIDTH-1:0]       address,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]       writedata,
  input  logic [BYTEENABLE_WIDTH-1:0] byteenable,
  output logic                        waitrequest,
  output logic [DATA_WIDTH-1:0]       readdata,
  output logic                        readdatavalid,
  output logic                        writeack
);

  localparam int unsigned OffW = $clog2(BYTEENABLE_WIDTH);

  typedef logic [DEPTH_LOG2-1:0]       widx_t;
  typedef logic [BURSTCOUNT_WIDTH-1:0] cnt_t;

  kernel_mem_scratchpad_state_e state_q, state_d;
  cnt_t  cnt_q, cnt_d;
  widx_t widx_q, widx_d;
  logic  wack_q, wack_d;
  logic  rv1_q, rdv_q;
  logic [DATA_WIDTH-1:0] readdata_q;

  logic  ram_we, ram_re;
  widx_t ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  widx_t cmd_widx;
  cnt_t  first_rem;
  logic  unused_addr;

  assign cmd_widx    = address[OffW +: DEPTH_LOG2];
  assign unused_addr = ^{address[ADDR_WIDTH-1:OffW+DEPTH_LOG2], address[OffW-1:0]};
  // Beats remaining after the first; burstcount 0 behaves as 1.
  assign first_rem   = (burstcount == '0) ? '0 : burstcount - cnt_t'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (write) begin
          if (first_rem != '0) state_d = StWr;
        end else if (read && first_rem != '0) begin
          state_d = StRd;
        end
      end
      StWr:    if (write && cnt_q == cnt_t'(1)) state_d = StIdle;
      StRd:    if (cnt_q == cnt_t'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = widx_q;
    ram_raddr = widx_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    wack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write) begin
          ram_we    = 1'b1;
          ram_waddr = cmd_widx;
          cnt_d     = first_rem;
          widx_d    = cmd_widx + widx_t'(1);
          wack_d    = (first_rem == '0);
        end else if (read) begin
          ram_re    = 1'b1;
          ram_raddr = cmd_widx;
          cnt_d     = first_rem;
          widx_d    = cmd_widx + widx_t'(1);
        end
      end
      StWr: begin
        if (write) begin
          ram_we = 1'b1;
          cnt_d  = cnt_q - cnt_t'(1);
          widx_d = widx_q + widx_t'(1);
          wack_d = (cnt_q == cnt_t'(1));
        end
      end
      StRd: begin
        ram_re = 1'b1;
        cnt_d  = cnt_q - cnt_t'(1);
        widx_d = widx_q + widx_t'(1);
      end
      default: ;
    endcase
  end

  // Read-valid pipeline drains independently of the FSM; reset flushes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      widx_q     <= '0;
      wack_q     <= 1'b0;
      rv1_q      <= 1'b0;
      rdv_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      widx_q <= widx_d;
      wack_q <= wack_d;
      rv1_q  <= ram_re;
      rdv_q  <= rv1_q;
      if (rv1_q) readdata_q <= ram_rdata;
    end
  end

  kernel_mem_scratchpad_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we && !reset),
    .waddr(ram_waddr),
    .be   (byteenable),
    .wdata(writedata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign waitrequest   = reset || (state_q == StRd);
  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;
  assign writeack      = wack_q;

`ifndef SYNTHESIS
  a_no_rd_wr_same_cycle: assert property (@(posedge clk) disable iff (reset)
    !(state_q == StIdle && read && write));
  a_no_rd_in_wr: assert property (@(posedge clk) disable iff (reset)
    !(state_q == StWr && read));
`endif

endmodule

// File: tb/tb_kernel_mem_scratchpad.sv
// Directed bench for kernel_mem_scratchpad: bursts, wrap, aliasing, byte enables, gaps, reset.
module tb_kernel_mem_scratchpad;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address = '0;
  logic [4:0]  burstcount = '0;
  logic [63:0] writedata = '0;
  logic [7:0]  byteenable = '0;
  logic        waitrequest, readdatavalid, writeack;
  logic [63:0] readdata;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] D1  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] D2  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D4  = 64'h1357_9BDF_2468_ACE0;
  localparam logic [63:0] D5  = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] D5N = 64'h5555_AAAA_5555_AAAA;

  always #5 clk = ~clk;

  kernel_mem_scratchpad dut (
    .clk          (clk),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .burstcount   (burstcount),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .writeack     (writeack)
  );

  function automatic logic [63:0] beat(input logic [63:0] d0, input int i);
    logic [7:0] b;
    b = 8'(i);
    return d0 ^ {8{b}};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] got[$];
  int first_k, last_k, wcnt;

  // Issues a read at the current cycle T and records beats seen at T+1..T+n+4.
  task automatic read_burst(input logic [31:0] a, input int n);
    got.delete();
    first_k = -1;
    last_k  = -1;
    wcnt    = 0;
    read = 1'b1;
    address = a;
    burstcount = 5'(n);
    tick;
    read = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      if (waitrequest) wcnt++;
      if (readdatavalid) begin
        got.push_back(readdata);
        if (first_k < 0) first_k = k;
        last_k = k;
      end
      tick;
    end
  endtask

  task automatic check_burst(input string tag, input logic [63:0] d0, input int n,
                             input int exp_w);
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    chk({tag, "_first_lat"}, 64'(first_k), 64'd2);
    chk({tag, "_contig"}, 64'(last_k - first_k), 64'(n - 1));
    chk({tag, "_wait_cycles"}, 64'(wcnt), 64'(exp_w));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), (i < got.size()) ? got[i] : 64'hx, beat(d0, i));
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input int n, input logic [63:0] d0,
                             input logic [7:0] be, input string tag);
    write = 1'b1;
    address = a;
    burstcount = 5'(n);
    byteenable = be;
    for (int i = 0; i < n; i++) begin
      writedata = beat(d0, i);
      tick;
    end
    write = 1'b0;
    chk({tag, "_wack"}, 64'(writeack), 64'd1);
    tick;
  endtask

  int acc_k, wack_k, overlap, nrd, k6, extra;

  initial begin
    tick;
    tick;
    chk("rst_waitrequest", 64'(waitrequest), 64'd1);
    chk("rst_rdv", 64'(readdatavalid), 64'd0);
    chk("rst_wack", 64'(writeack), 64'd0);
    chk("rst_readdata", readdata, 64'd0);
    reset = 1'b0;
    tick;
    chk("idle_waitrequest", 64'(waitrequest), 64'd0);

    // Single write then single read of word 8
    write_burst(32'h40, 1, D1, 8'hFF, "t1");
    chk("t1_wack_once", 64'(writeack), 64'd0);
    read_burst(32'h40, 1);
    check_burst("t1_rd", D1, 1, 0);

    // Wrapping burst at word 0x3FE, plus aliased single reads
    write_burst(32'h1FF0, 4, D2, 8'hFF, "t2");
    read_burst(32'h1FF0, 4);
    check_burst("t2_rd", D2, 4, 3);
    read_burst(32'h0, 1);
    chk("t2_wrap_word0", (got.size() > 0) ? got[0] : 64'hx, beat(D2, 2));
    read_burst(32'h2008, 1);
    chk("t2_alias_word1", (got.size() > 0) ? got[0] : 64'hx, beat(D2, 3));

    // Partial byte enable
    write_burst(32'h80, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "t3a");
    write_burst(32'h80, 1, 64'h0, 8'h01, "t3b");
    read_burst(32'h80, 1);
    chk("t3_partial_be", (got.size() > 0) ? got[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FF00);

    // N=3 write with a 2-cycle gap after beat 1
    write = 1'b1;
    address = 32'h100;
    burstcount = 5'd3;
    byteenable = 8'hFF;
    writedata = beat(D4, 0);
    tick;
    writedata = beat(D4, 1);
    chk("t4_wack_b1", 64'(writeack), 64'd0);
    tick;
    write = 1'b0;
    chk("t4_wack_gap1", 64'(writeack), 64'd0);
    tick;
    chk("t4_wack_gap2", 64'(writeack), 64'd0);
    tick;
    write = 1'b1;
    address = 32'hFFFF_FFFF;
    writedata = beat(D4, 2);
    tick;
    write = 1'b0;
    chk("t4_wack_last", 64'(writeack), 64'd1);
    tick;
    chk("t4_wack_once", 64'(writeack), 64'd0);
    read_burst(32'h100, 3);
    check_burst("t4_rd", D4, 3, 2);

    // N=8 read followed by a write to its first word
    write_burst(32'h200, 8, D5, 8'hFF, "t5w");
    read = 1'b1;
    address = 32'h200;
    burstcount = 5'd8;
    tick;
    read = 1'b0;
    write = 1'b1;
    address = 32'h200;
    burstcount = 5'd1;
    writedata = D5N;
    byteenable = 8'hFF;
    got.delete();
    acc_k = -1;
    wack_k = -1;
    overlap = 0;
    for (int k = 1; k <= 14; k++) begin
      logic accepted;
      if (readdatavalid) got.push_back(readdata);
      if (writeack) begin
        wack_k = k;
        if (readdatavalid) overlap = 1;
      end
      accepted = write && !waitrequest;
      if (accepted) acc_k = k;
      tick;
      if (accepted) write = 1'b0;
    end
    write = 1'b0;
    chk("t5_write_accept", 64'(acc_k), 64'd8);
    chk("t5_wack_cycle", 64'(wack_k), 64'd9);
    chk("t5_wack_overlap", 64'(overlap), 64'd1);
    chk("t5_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_beat%0d", i), (i < got.size()) ? got[i] : 64'hx, beat(D5, i));
    end
    read_burst(32'h200, 1);
    chk("t5_new_data", (got.size() > 0) ? got[0] : 64'hx, D5N);

    // Reset after 3 beats of an N=8 read
    read = 1'b1;
    address = 32'h200;
    burstcount = 5'd8;
    tick;
    read = 1'b0;
    nrd = 0;
    k6 = 1;
    while (nrd < 3 && k6 < 12) begin
      if (readdatavalid) nrd++;
      if (nrd < 3) begin
        tick;
        k6++;
      end
    end
    chk("t6_three_beats", 64'(nrd), 64'd3);
    reset = 1'b1;
    tick;
    chk("t6_wr_in_reset1", 64'(waitrequest), 64'd1);
    chk("t6_rdv_flushed", 64'(readdatavalid), 64'd0);
    tick;
    chk("t6_wr_in_reset2", 64'(waitrequest), 64'd1);
    reset = 1'b0;
    tick;
    chk("t6_wr_after_reset", 64'(waitrequest), 64'd0);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      if (readdatavalid) extra++;
      tick;
    end
    chk("t6_no_stray_rdv", 64'(extra), 64'd0);
    read_burst(32'h1FF0, 4);
    check_burst("t6_retained", D2, 4, 3);
    read_burst(32'h200, 1);
    chk("t6_retained_w40", (got.size() > 0) ? got[0] : 64'hx, D5N);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
